// File: rtl/rs_pkg.sv
// Shared field layout, opcode constants and operand wakeup helpers for the reservation station.
package rs_pkg;

  localparam int RS_ENTRY_W = 144;
  localparam int VALID_BIT  = 143;
  localparam int OP_HI      = 110;
  localparam int OP_LO      = 105;
  localparam int RS_FLAG    = 104;
  localparam int RS_HI      = 103;
  localparam int RS_LO      = 72;
  localparam int RT_FLAG    = 71;
  localparam int RT_HI      = 70;
  localparam int RT_LO      = 39;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef logic [RS_ENTRY_W-1:0] rs_entry_t;

  function automatic logic needs_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  // Rs and Rt are matched independently so one broadcast can satisfy both.
  function automatic rs_entry_t wakeup(input rs_entry_t e, input logic cdb_valid,
                                       input logic [31:0] cdb_tag, input logic [31:0] cdb_data);
    rs_entry_t r;
    r = e;
    if (cdb_valid && e[VALID_BIT]) begin
      if (!e[RS_FLAG] && (e[RS_HI:RS_LO] == cdb_tag)) begin
        r[RS_HI:RS_LO] = cdb_data;
        r[RS_FLAG]     = 1'b1;
      end
      if (!e[RT_FLAG] && (e[RT_HI:RT_LO] == cdb_tag)) begin
        r[RT_HI:RT_LO] = cdb_data;
        r[RT_FLAG]     = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic is_ready(input rs_entry_t e);
    return e[VALID_BIT] && e[RS_FLAG] && (e[RT_FLAG] || !needs_rt(e[OP_HI:OP_LO]));
  endfunction

endpackage

// File: rtl/rs_slot.sv
// One reservation-station slot: holds an entry, applies CDB wakeup, and reports readiness.
module rs_slot
  import rs_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear,
  input  logic        load,
  input  rs_entry_t   load_entry,
  input  logic        shift_in,
  input  rs_entry_t   shift_entry,
  input  logic        cdb_valid,
  input  logic [31:0] cdb_tag,
  input  logic [31:0] cdb_data,
  output rs_entry_t   fwd_entry,
  output logic        ready
);

  rs_entry_t entry_q;
  rs_entry_t entry_d;

  // Load wins over shift: a dispatch may land in the slot vacated by the shift.
  always_comb begin
    fwd_entry = wakeup(entry_q, cdb_valid, cdb_tag, cdb_data);
    ready     = is_ready(fwd_entry);
    entry_d   = fwd_entry;
    if (clear)         entry_d = '0;
    else if (load)     entry_d = load_entry;
    else if (shift_in) entry_d = shift_entry;
  end

  always_ff @(posedge Clk) begin
    if (Reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

endmodule

// File: rtl/reservation_station.sv
// Compacting reservation station: oldest-ready select, slot shift control, occupancy count, issue register.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 144
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Flush,
  input  logic                       DispValid,
  input  logic [ENTRY_W-1:0]         DispEntry,
  output logic                       DispFull,
  input  logic                       CdbValid,
  input  logic [31:0]                CdbTag,
  input  logic [31:0]                CdbData,
  input  logic                       IssueStall,
  output logic [ENTRY_W-1:0]         IssueEntry,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  rs_entry_t        issue_q, issue_d;
  rs_entry_t        fwd [DEPTH];
  logic [DEPTH-1:0] ready, load, shift_in;
  rs_entry_t        disp_entry_fwd;
  logic             disp_ok, issue_found, issue_valid;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] disp_idx;
  logic             disp_unused_bit;

  // The incoming valid bit is not trusted; it is forced on before forwarding.
  assign disp_unused_bit = DispEntry[VALID_BIT];
  assign disp_entry_fwd  = wakeup({1'b1, DispEntry[ENTRY_W-2:0]}, CdbValid, CdbTag, CdbData);
  assign DispFull        = (count_q == CNT_W'(DEPTH));
  assign disp_ok         = DispValid && !DispFull;

  always_comb begin
    issue_found = 1'b0;
    sel         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!issue_found && ready[i]) begin
        issue_found = 1'b1;
        sel         = IDX_W'(i);
      end
    end
  end

  assign issue_valid = issue_found && !IssueStall;
  assign disp_idx    = count_q - CNT_W'(issue_valid);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_entry_t shift_entry;
    assign shift_in[i] = issue_valid && (i >= int'(sel));
    assign load[i]     = disp_ok && (disp_idx == CNT_W'(i));
    if (i == DEPTH-1) begin : g_top
      assign shift_entry = '0;
    end else begin : g_mid
      assign shift_entry = fwd[i+1];
    end
    rs_slot u_slot (
      .Clk        (Clk),
      .Reset      (Reset),
      .clear      (Flush),
      .load       (load[i]),
      .load_entry (disp_entry_fwd),
      .shift_in   (shift_in[i]),
      .shift_entry(shift_entry),
      .cdb_valid  (CdbValid),
      .cdb_tag    (CdbTag),
      .cdb_data   (CdbData),
      .fwd_entry  (fwd[i]),
      .ready      (ready[i])
    );
  end

  always_comb begin
    issue_d = '0;
    if (issue_valid) begin
      issue_d            = fwd[sel];
      issue_d[VALID_BIT] = 1'b1;
    end
    count_d = count_q;
    if (disp_ok && !issue_valid)      count_d = count_q + 1'b1;
    else if (!disp_ok && issue_valid) count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      count_q <= '0;
      issue_q <= '0;
    end else begin
      count_q <= count_d;
      issue_q <= issue_d;
    end
  end

  assign IssueEntry = issue_q;
  assign Count      = count_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed table-driven bench for reservation_station with hand-computed expected issue/count/full values.
module tb_reservation_station;

  logic         Clk = 1'b0;
  logic         Reset, Flush, DispValid, CdbValid, IssueStall;
  logic [143:0] DispEntry, IssueEntry;
  logic [31:0]  CdbTag, CdbData;
  logic         DispFull;
  logic [2:0]   Count;

  int checks = 0;
  int errors = 0;

  reservation_station #(.DEPTH(4), .ENTRY_W(144)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .DispValid(DispValid), .DispEntry(DispEntry),
    .DispFull(DispFull), .CdbValid(CdbValid), .CdbTag(CdbTag), .CdbData(CdbData),
    .IssueStall(IssueStall), .IssueEntry(IssueEntry), .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         dv;
    logic [143:0] de;
    logic         cv;
    logic [31:0]  ct;
    logic [31:0]  cd;
    logic         st;
    logic         fl;
    logic [143:0] ei;
    logic [2:0]   ec;
    logic         ef;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [143:0] mk(input logic [5:0] op, input logic [31:0] tag,
                                      input logic rsf, input logic [31:0] rs,
                                      input logic rtf, input logic [31:0] rt);
    return {1'b1, tag, op, rsf, rs, rtf, rt, 1'b1, 32'h0000_1234, 6'h20};
  endfunction

  function automatic logic [143:0] nv(input logic [143:0] e);
    logic [143:0] r;
    r = e;
    r[143] = 1'b0;
    return r;
  endfunction

  function automatic logic [143:0] with_rs(input logic [143:0] e, input logic [31:0] v);
    logic [143:0] r;
    r = e;
    r[103:72] = v;
    r[104]    = 1'b1;
    return r;
  endfunction

  function automatic logic [143:0] with_rt(input logic [143:0] e, input logic [31:0] v);
    logic [143:0] r;
    r = e;
    r[70:39] = v;
    r[71]    = 1'b1;
    return r;
  endfunction

  task automatic add(input logic dv, input logic [143:0] de, input logic cv, input logic [31:0] ct,
                     input logic [31:0] cd, input logic st, input logic fl,
                     input logic [143:0] ei, input logic [2:0] ec, input logic ef);
    vec_t v;
    v.dv = dv; v.de = de; v.cv = cv; v.ct = ct; v.cd = cd; v.st = st; v.fl = fl;
    v.ei = ei; v.ec = ec; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic idle_row(input logic [143:0] ei, input logic [2:0] ec, input logic ef);
    add(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, ei, ec, ef);
  endtask

  task automatic chk144(input string name, input int idx, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk3(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Flush = 0; DispValid = 0; DispEntry = '0; CdbValid = 0; CdbTag = '0; CdbData = '0; IssueStall = 0;
  endtask

  logic [143:0] ea, eb, c0, c1, c2, c3, ed, ee, ef_e, eg, eh, ei_e, ej, k0, k1, k2, el;

  initial begin
    Reset = 1'b1;
    clear_inputs();

    ea   = mk(6'b001000, 32'h1, 1'b1, 32'h100, 1'b0, 32'h5);
    eb   = mk(6'b000000, 32'h2, 1'b1, 32'h11, 1'b0, 32'h7);
    c0   = mk(6'b000000, 32'h10, 1'b0, 32'h20, 1'b1, 32'h3);
    c1   = mk(6'b000000, 32'h11, 1'b0, 32'h21, 1'b1, 32'h3);
    c2   = mk(6'b000000, 32'h12, 1'b0, 32'h22, 1'b1, 32'h3);
    c3   = mk(6'b000000, 32'h13, 1'b0, 32'h23, 1'b1, 32'h3);
    ed   = mk(6'b000000, 32'h14, 1'b0, 32'h24, 1'b1, 32'h3);
    ee   = mk(6'b000000, 32'h15, 1'b0, 32'h30, 1'b1, 32'h3);
    ef_e = mk(6'b101011, 32'h16, 1'b0, 32'h40, 1'b0, 32'h40);
    eg   = mk(6'b001000, 32'h17, 1'b1, 32'hA, 1'b0, 32'h9);
    eh   = mk(6'b000100, 32'h18, 1'b1, 32'hB, 1'b1, 32'hC);
    ei_e = mk(6'b001000, 32'h19, 1'b1, 32'hD, 1'b0, 32'h9);
    ej   = mk(6'b001000, 32'h1A, 1'b1, 32'hE, 1'b0, 32'h9);
    k0   = mk(6'b000000, 32'h20, 1'b0, 32'h50, 1'b1, 32'h3);
    k1   = mk(6'b000000, 32'h21, 1'b0, 32'h51, 1'b1, 32'h3);
    k2   = mk(6'b000000, 32'h22, 1'b0, 32'h52, 1'b1, 32'h3);
    el   = mk(6'b001000, 32'h23, 1'b1, 32'h60, 1'b0, 32'h9);

    // addi with ready Rs: issues one edge after dispatch, valid bit forced on
    add(1'b1, nv(ea), 0, 0, 0, 0, 0, '0, 3'd1, 0);
    idle_row(ea, 3'd0, 0);
    idle_row('0, 3'd0, 0);
    // R-type waiting on Rt tag 7
    add(1'b1, eb, 0, 0, 0, 0, 0, '0, 3'd1, 0);
    idle_row('0, 3'd1, 0);
    add(1'b0, '0, 1, 32'h7, 32'h55, 0, 0, with_rt(eb, 32'h55), 3'd0, 0);
    idle_row('0, 3'd0, 0);
    // fill, drop 5th, wake out of order
    add(1'b1, c0, 0, 0, 0, 0, 0, '0, 3'd1, 0);
    add(1'b1, c1, 0, 0, 0, 0, 0, '0, 3'd2, 0);
    add(1'b1, c2, 0, 0, 0, 0, 0, '0, 3'd3, 0);
    add(1'b1, c3, 0, 0, 0, 0, 0, '0, 3'd4, 1);
    add(1'b1, ed, 0, 0, 0, 0, 0, '0, 3'd4, 1);
    add(1'b0, '0, 1, 32'h22, 32'hAA, 0, 0, with_rs(c2, 32'hAA), 3'd3, 0);
    add(1'b0, '0, 1, 32'h20, 32'hB0, 0, 0, with_rs(c0, 32'hB0), 3'd2, 0);
    add(1'b0, '0, 1, 32'h23, 32'hB3, 0, 0, with_rs(c3, 32'hB3), 3'd1, 0);
    add(1'b0, '0, 1, 32'h21, 32'hB1, 0, 0, with_rs(c1, 32'hB1), 3'd0, 0);
    add(1'b0, '0, 1, 32'h24, 32'hB4, 0, 0, '0, 3'd0, 0);
    // dispatch with same-cycle CDB forwarding into the new entry
    add(1'b1, ee, 1, 32'h30, 32'h77, 0, 0, '0, 3'd1, 0);
    idle_row(with_rs(ee, 32'h77), 3'd0, 0);
    // one broadcast wakes both Rs and Rt of a store
    add(1'b1, ef_e, 0, 0, 0, 0, 0, '0, 3'd1, 0);
    add(1'b0, '0, 1, 32'h40, 32'h99, 0, 0, with_rt(with_rs(ef_e, 32'h99), 32'h99), 3'd0, 0);
    // stall holds two ready entries, then oldest first
    add(1'b1, eg, 0, 0, 0, 1, 0, '0, 3'd1, 0);
    add(1'b1, eh, 0, 0, 0, 1, 0, '0, 3'd2, 0);
    add(1'b0, '0, 0, 0, 0, 1, 0, '0, 3'd2, 0);
    add(1'b0, '0, 0, 0, 0, 1, 0, '0, 3'd2, 0);
    idle_row(eg, 3'd1, 0);
    idle_row(eh, 3'd0, 0);
    // dispatch and issue in the same cycle keep the count unchanged
    add(1'b1, ei_e, 0, 0, 0, 0, 0, '0, 3'd1, 0);
    add(1'b1, ej, 0, 0, 0, 0, 0, ei_e, 3'd1, 0);
    idle_row(ej, 3'd0, 0);
    // flush with concurrent dispatch
    add(1'b1, k0, 0, 0, 0, 0, 0, '0, 3'd1, 0);
    add(1'b1, k1, 0, 0, 0, 0, 0, '0, 3'd2, 0);
    add(1'b1, k2, 0, 0, 0, 0, 0, '0, 3'd3, 0);
    add(1'b1, el, 0, 0, 0, 0, 1, '0, 3'd0, 0);
    add(1'b0, '0, 1, 32'h50, 32'hC0, 0, 0, '0, 3'd0, 0);
    idle_row('0, 3'd0, 0);

    repeat (2) @(posedge Clk);
    #1;
    chk144("reset_issue", -1, IssueEntry, '0);
    chk3("reset_count", -1, Count, 3'd0);
    chk3("reset_full", -1, {2'b0, DispFull}, 3'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      DispValid = vecs[i].dv; DispEntry = vecs[i].de; CdbValid = vecs[i].cv;
      CdbTag = vecs[i].ct; CdbData = vecs[i].cd; IssueStall = vecs[i].st; Flush = vecs[i].fl;
      @(posedge Clk);
      #1;
      chk144("issue", i, IssueEntry, vecs[i].ei);
      chk3("count", i, Count, vecs[i].ec);
      chk3("full", i, {2'b0, DispFull}, {2'b0, vecs[i].ef});
      clear_inputs();
    end

    // Reset with held entries and concurrent dispatch/CDB clears everything
    @(negedge Clk);
    DispValid = 1; DispEntry = c0;
    @(negedge Clk);
    DispEntry = c1;
    @(negedge Clk);
    Reset = 1; DispEntry = ea; CdbValid = 1; CdbTag = 32'h20; CdbData = 32'h1;
    @(posedge Clk);
    #1;
    chk3("mid_reset_count", -2, Count, 3'd0);
    chk144("mid_reset_issue", -2, IssueEntry, '0);
    @(negedge Clk);
    Reset = 0;
    clear_inputs();
    CdbValid = 1; CdbTag = 32'h21; CdbData = 32'h2;
    @(posedge Clk);
    #1;
    chk144("after_reset_issue", -2, IssueEntry, '0);
    chk3("after_reset_count", -2, Count, 3'd0);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
